// File: rtl/tb_rsp_scoreboard_pkg.sv
// Shared types and helpers for the response scoreboard.
// Imported by the channel checker and the top.
package tb_rsp_scoreboard_pkg;

  typedef enum logic [1:0] {
    CMP_NONE,
    CMP_MATCH,
    CMP_MISMATCH
  } cmp_result_e;

  // Bit width for an index over n items, never below one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tb_rsp_chan_checker.sv
// One channel: per-ID ref/DUT queues, round-robin pairing,
// comparator and no-progress watchdog.
module tb_rsp_chan_checker
  import tb_rsp_scoreboard_pkg::*;
#(
  parameter int DataWidth     = 64,
  parameter int IdWidth       = 2,
  parameter int FifoDepth     = 8,
  parameter int TimeoutCycles = 1024,
  parameter bit CompareLast   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 ref_valid_i,
  input  logic [IdWidth-1:0]   ref_id_i,
  input  logic [DataWidth-1:0] ref_data_i,
  input  logic [1:0]           ref_resp_i,
  input  logic                 ref_last_i,
  input  logic                 dut_valid_i,
  input  logic [IdWidth-1:0]   dut_id_i,
  input  logic [DataWidth-1:0] dut_data_i,
  input  logic [1:0]           dut_resp_i,
  input  logic                 dut_last_i,
  output logic                 match_o,
  output logic                 mismatch_o,
  output logic [IdWidth-1:0]   cap_id_o,
  output logic [DataWidth-1:0] cap_ref_o,
  output logic [DataWidth-1:0] cap_dut_o,
  output logic                 overflow_o,
  output logic                 timeout_o,
  output logic                 empty_o
);

  localparam int NumIds = 1 << IdWidth;
  localparam int AW     = $clog2(FifoDepth);
  localparam int WdW    = min1_clog2(TimeoutCycles + 1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } beat_t;

  // side 0 = golden model, side 1 = DUT
  beat_t                    mem [2][NumIds][FifoDepth];
  logic [AW:0]              wptr [2][NumIds];
  logic [AW:0]              rptr [2][NumIds];
  logic [1:0][NumIds-1:0]   empty;
  logic [1:0][NumIds-1:0]   full;
  logic [1:0]               in_valid;
  logic [IdWidth-1:0]       in_id [2];
  beat_t                    in_beat [2];
  logic [1:0]               push;
  logic [NumIds-1:0]        cand;
  logic [IdWidth-1:0]       rr_q;
  logic [IdWidth-1:0]       sel;
  logic [IdWidth-1:0]       idx;
  logic                     hit;
  beat_t                    head_ref;
  beat_t                    head_dut;
  cmp_result_e              result;
  logic [WdW-1:0]           wd_q;

  assign in_valid   = {dut_valid_i, ref_valid_i};
  assign in_id[0]   = ref_id_i;
  assign in_id[1]   = dut_id_i;
  assign in_beat[0] = {ref_data_i, ref_resp_i, ref_last_i};
  assign in_beat[1] = {dut_data_i, dut_resp_i, dut_last_i};

  // Queue occupancy flags from the pointer pairs.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NumIds; i++) begin
        empty[s][i] = wptr[s][i] == rptr[s][i];
        full[s][i]  = (wptr[s][i] - rptr[s][i])
                      == (AW+1)'(FifoDepth);
      end
    end
  end

  // A beat is dropped when its queue is already full.
  always_comb begin
    push = '0;
    for (int s = 0; s < 2; s++) begin
      push[s] = in_valid[s] && !full[s][in_id[s]];
    end
  end

  assign overflow_o = |(in_valid & ~push);
  assign cand       = ~empty[0] & ~empty[1];
  assign empty_o    = &empty;

  // Round-robin pick, starting one past the last served ID.
  always_comb begin
    sel = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 1; k <= NumIds; k++) begin
      idx = rr_q + IdWidth'(k);
      if (!hit && cand[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  assign head_ref = mem[0][sel][rptr[0][sel][AW-1:0]];
  assign head_dut = mem[1][sel][rptr[1][sel][AW-1:0]];

  // Compare the two heads of the selected ID.
  always_comb begin
    result = CMP_NONE;
    if (hit) begin
      if (head_ref.data == head_dut.data &&
          head_ref.resp == head_dut.resp &&
          (!CompareLast || head_ref.last == head_dut.last))
        result = CMP_MATCH;
      else
        result = CMP_MISMATCH;
    end
  end

  assign match_o    = result == CMP_MATCH;
  assign mismatch_o = result == CMP_MISMATCH;
  assign cap_id_o   = sel;
  assign cap_ref_o  = head_ref.data;
  assign cap_dut_o  = head_dut.data;

  // Queue storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s])
        mem[s][in_id[s]][wptr[s][in_id[s]][AW-1:0]]
          <= in_beat[s];
    end
  end

  // Pointer and arbiter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < NumIds; i++) begin
          wptr[s][i] <= '0;
          rptr[s][i] <= '0;
        end
      end
      rr_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < NumIds; i++) begin
          if (push[s] && in_id[s] == IdWidth'(i))
            wptr[s][i] <= wptr[s][i] + 1'b1;
          if (hit && sel == IdWidth'(i))
            rptr[s][i] <= rptr[s][i] + 1'b1;
        end
      end
      if (hit) rr_q <= sel;
    end
  end

  // Watchdog: counts cycles with pending beats and no pairing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      wd_q <= '0;
    else if (clear_i || hit || empty_o || TimeoutCycles == 0)
      wd_q <= '0;
    else if (wd_q != WdW'(TimeoutCycles))
      wd_q <= wd_q + 1'b1;
  end

  assign timeout_o = (TimeoutCycles != 0) &&
                     (wd_q == WdW'(TimeoutCycles));

endmodule

// File: rtl/tb_rsp_scoreboard.sv
// Multi-channel response scoreboard: per-channel checkers,
// saturating totals, sticky flags and first-mismatch capture.
module tb_rsp_scoreboard
  import tb_rsp_scoreboard_pkg::*;
#(
  parameter int NumChannels   = 2,
  parameter int DataWidth     = 64,
  parameter int IdWidth       = 2,
  parameter int FifoDepth     = 8,
  parameter int CntWidth      = 32,
  parameter int TimeoutCycles = 1024,
  parameter bit CompareLast   = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic [NumChannels-1:0]           ref_valid_i,
  input  logic [NumChannels*IdWidth-1:0]   ref_id_i,
  input  logic [NumChannels*DataWidth-1:0] ref_data_i,
  input  logic [NumChannels*2-1:0]         ref_resp_i,
  input  logic [NumChannels-1:0]           ref_last_i,
  input  logic [NumChannels-1:0]           dut_valid_i,
  input  logic [NumChannels*IdWidth-1:0]   dut_id_i,
  input  logic [NumChannels*DataWidth-1:0] dut_data_i,
  input  logic [NumChannels*2-1:0]         dut_resp_i,
  input  logic [NumChannels-1:0]           dut_last_i,
  output logic [CntWidth-1:0]              match_cnt_o,
  output logic [CntWidth-1:0]              mismatch_cnt_o,
  output logic                             mismatch_o,
  output logic                             overflow_o,
  output logic                             timeout_o,
  output logic                             idle_o,
  output logic [min1_clog2(NumChannels)-1:0] first_chan_o,
  output logic [IdWidth-1:0]               first_id_o,
  output logic [DataWidth-1:0]             first_ref_o,
  output logic [DataWidth-1:0]             first_dut_o
);

  localparam int ChW = min1_clog2(NumChannels);

  logic [NumChannels-1:0] ch_match;
  logic [NumChannels-1:0] ch_mismatch;
  logic [NumChannels-1:0] ch_overflow;
  logic [NumChannels-1:0] ch_timeout;
  logic [NumChannels-1:0] ch_empty;
  logic [IdWidth-1:0]     ch_id  [NumChannels];
  logic [DataWidth-1:0]   ch_ref [NumChannels];
  logic [DataWidth-1:0]   ch_dut [NumChannels];

  logic [CntWidth:0]      match_inc, mismatch_inc;
  logic [CntWidth:0]      match_sum, mismatch_sum;
  logic [ChW-1:0]         fc_chan;
  logic [IdWidth-1:0]     fc_id;
  logic [DataWidth-1:0]   fc_ref, fc_dut;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    tb_rsp_chan_checker #(
      .DataWidth    (DataWidth),
      .IdWidth      (IdWidth),
      .FifoDepth    (FifoDepth),
      .TimeoutCycles(TimeoutCycles),
      .CompareLast  (CompareLast)
    ) u_chk (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .ref_valid_i(ref_valid_i[c]),
      .ref_id_i   (ref_id_i[c*IdWidth +: IdWidth]),
      .ref_data_i (ref_data_i[c*DataWidth +: DataWidth]),
      .ref_resp_i (ref_resp_i[c*2 +: 2]),
      .ref_last_i (ref_last_i[c]),
      .dut_valid_i(dut_valid_i[c]),
      .dut_id_i   (dut_id_i[c*IdWidth +: IdWidth]),
      .dut_data_i (dut_data_i[c*DataWidth +: DataWidth]),
      .dut_resp_i (dut_resp_i[c*2 +: 2]),
      .dut_last_i (dut_last_i[c]),
      .match_o    (ch_match[c]),
      .mismatch_o (ch_mismatch[c]),
      .cap_id_o   (ch_id[c]),
      .cap_ref_o  (ch_ref[c]),
      .cap_dut_o  (ch_dut[c]),
      .overflow_o (ch_overflow[c]),
      .timeout_o  (ch_timeout[c]),
      .empty_o    (ch_empty[c])
    );
  end

  assign idle_o = &ch_empty;

  // Sum this cycle's per-channel events onto the totals.
  always_comb begin
    match_inc    = '0;
    mismatch_inc = '0;
    for (int c = 0; c < NumChannels; c++) begin
      match_inc    = match_inc + (CntWidth+1)'(ch_match[c]);
      mismatch_inc = mismatch_inc + (CntWidth+1)'(ch_mismatch[c]);
    end
    match_sum    = {1'b0, match_cnt_o} + match_inc;
    mismatch_sum = {1'b0, mismatch_cnt_o} + mismatch_inc;
  end

  // Lowest mismatching channel supplies the capture.
  always_comb begin
    fc_chan = '0;
    fc_id   = '0;
    fc_ref  = '0;
    fc_dut  = '0;
    for (int c = NumChannels-1; c >= 0; c--) begin
      if (ch_mismatch[c]) begin
        fc_chan = ChW'(c);
        fc_id   = ch_id[c];
        fc_ref  = ch_ref[c];
        fc_dut  = ch_dut[c];
      end
    end
  end

  // Totals, sticky flags and first-mismatch record.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      match_cnt_o    <= '0;
      mismatch_cnt_o <= '0;
      mismatch_o     <= 1'b0;
      overflow_o     <= 1'b0;
      timeout_o      <= 1'b0;
      first_chan_o   <= '0;
      first_id_o     <= '0;
      first_ref_o    <= '0;
      first_dut_o    <= '0;
    end else if (clear_i) begin
      match_cnt_o    <= '0;
      mismatch_cnt_o <= '0;
      mismatch_o     <= 1'b0;
      overflow_o     <= 1'b0;
      timeout_o      <= 1'b0;
      first_chan_o   <= '0;
      first_id_o     <= '0;
      first_ref_o    <= '0;
      first_dut_o    <= '0;
    end else begin
      match_cnt_o <= match_sum[CntWidth] ? '1
                     : match_sum[CntWidth-1:0];
      mismatch_cnt_o <= mismatch_sum[CntWidth] ? '1
                        : mismatch_sum[CntWidth-1:0];
      mismatch_o <= mismatch_o | (|ch_mismatch);
      overflow_o <= overflow_o | (|ch_overflow);
      timeout_o  <= timeout_o | (|ch_timeout);
      if (!mismatch_o && |ch_mismatch) begin
        first_chan_o <= fc_chan;
        first_id_o   <= fc_id;
        first_ref_o  <= fc_ref;
        first_dut_o  <= fc_dut;
      end
    end
  end

endmodule

// File: tb/tb_tb_rsp_scoreboard.sv
// Directed bench for the response scoreboard.
// Expected values are hand-computed per scenario.
module tb_tb_rsp_scoreboard;

  localparam int NC = 2;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int CW = 32;
  localparam bit REF = 1'b0;
  localparam bit DUT = 1'b1;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [NC-1:0]    ref_valid, ref_last, dut_valid, dut_last;
  logic [NC*IW-1:0] ref_id, dut_id;
  logic [NC*DW-1:0] ref_data, dut_data;
  logic [NC*2-1:0]  ref_resp, dut_resp;
  logic [CW-1:0]    match_cnt, mismatch_cnt;
  logic             mismatch, overflow, timeout, idle;
  logic [0:0]       first_chan;
  logic [IW-1:0]    first_id;
  logic [DW-1:0]    first_ref, first_dut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tb_rsp_scoreboard #(
    .NumChannels  (NC),
    .DataWidth    (DW),
    .IdWidth      (IW),
    .FifoDepth    (8),
    .CntWidth     (CW),
    .TimeoutCycles(16),
    .CompareLast  (1'b1)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .ref_valid_i   (ref_valid),
    .ref_id_i      (ref_id),
    .ref_data_i    (ref_data),
    .ref_resp_i    (ref_resp),
    .ref_last_i    (ref_last),
    .dut_valid_i   (dut_valid),
    .dut_id_i      (dut_id),
    .dut_data_i    (dut_data),
    .dut_resp_i    (dut_resp),
    .dut_last_i    (dut_last),
    .match_cnt_o   (match_cnt),
    .mismatch_cnt_o(mismatch_cnt),
    .mismatch_o    (mismatch),
    .overflow_o    (overflow),
    .timeout_o     (timeout),
    .idle_o        (idle),
    .first_chan_o  (first_chan),
    .first_id_o    (first_id),
    .first_ref_o   (first_ref),
    .first_dut_o   (first_dut)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input bit side, input int ch, input int id,
                     input logic [63:0] d,
                     input logic [1:0] r = 2'b00);
    if (side == REF) begin
      ref_valid[ch]          = 1'b1;
      ref_id[ch*IW +: IW]    = IW'(id);
      ref_data[ch*DW +: DW]  = d;
      ref_resp[ch*2 +: 2]    = r;
      ref_last[ch]           = 1'b1;
    end else begin
      dut_valid[ch]          = 1'b1;
      dut_id[ch*IW +: IW]    = IW'(id);
      dut_data[ch*DW +: DW]  = d;
      dut_resp[ch*2 +: 2]    = r;
      dut_last[ch]           = 1'b1;
    end
  endtask

  task automatic idle_in();
    ref_valid = '0;
    dut_valid = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    ref_valid = '0; ref_id = '0; ref_data = '0;
    ref_resp = '0; ref_last = '0;
    dut_valid = '0; dut_id = '0; dut_data = '0;
    dut_resp = '0; dut_last = '0;
    step(2);
    rst = 1'b0;
    step();

    check("rst_match_cnt", match_cnt, 0);
    check("rst_mismatch_cnt", mismatch_cnt, 0);
    check("rst_flags", {mismatch, overflow, timeout}, 0);
    check("rst_idle", idle, 1);
    check("rst_first", {first_chan, first_id, first_ref[7:0]}, 0);

    // ordered match on ch0 id1
    put(REF, 0, 1, 64'hA5); step(); idle_in();
    check("t1_busy", idle, 0);
    put(DUT, 0, 1, 64'hA5); step(); idle_in();
    step(3);
    check("t1_match_cnt", match_cnt, 1);
    check("t1_mismatch", mismatch, 0);
    check("t1_idle", idle, 1);

    // DUT leads on ch1 id0
    do_clear();
    put(DUT, 1, 0, 64'h11); step();
    put(DUT, 1, 0, 64'h22); step(); idle_in();
    step(3);
    check("t2_wait_cnt", match_cnt, 0);
    put(REF, 1, 0, 64'h11); step();
    put(REF, 1, 0, 64'h22); step(); idle_in();
    step(3);
    check("t2_match_cnt", match_cnt, 2);
    check("t2_flags", {mismatch, overflow, timeout}, 0);
    check("t2_idle", idle, 1);

    // first mismatch capture, later mismatch ignored
    do_clear();
    put(REF, 1, 2, 64'hDEAD); put(DUT, 1, 2, 64'hBEEF);
    step(); idle_in(); step(3);
    put(REF, 0, 0, 64'h1); put(DUT, 0, 0, 64'h2);
    step(); idle_in(); step(3);
    check("t3_mismatch_cnt", mismatch_cnt, 2);
    check("t3_match_cnt", match_cnt, 0);
    check("t3_mismatch", mismatch, 1);
    check("t3_first_chan", first_chan, 1);
    check("t3_first_id", first_id, 2);
    check("t3_first_ref", first_ref, 64'hDEAD);
    check("t3_first_dut", first_dut, 64'hBEEF);

    // simultaneous mismatches: lowest channel wins; resp-only diff
    do_clear();
    put(REF, 0, 3, 64'h33, 2'b00); put(DUT, 0, 3, 64'h33, 2'b10);
    put(REF, 1, 1, 64'h44);        put(DUT, 1, 1, 64'h45);
    step(); idle_in(); step(3);
    check("t3b_mismatch_cnt", mismatch_cnt, 2);
    check("t3b_first_chan", first_chan, 0);
    check("t3b_first_id", first_id, 3);
    check("t3b_first_ref", first_ref, 64'h33);
    check("t3b_first_dut", first_dut, 64'h33);

    // overflow: 9 beats into depth-8 queue, 9th dropped
    do_clear();
    for (int i = 0; i < 9; i++) begin
      put(REF, 0, 3, 64'(i)); step();
    end
    idle_in(); step();
    check("t4_overflow", overflow, 1);
    check("t4_busy", idle, 0);
    for (int i = 0; i < 8; i++) begin
      put(DUT, 0, 3, 64'(i)); step();
    end
    idle_in(); step(3);
    check("t4_match_cnt", match_cnt, 8);
    check("t4_mismatch", mismatch, 0);
    check("t4_idle", idle, 1);

    // watchdog with a lone ref beat
    do_clear();
    put(REF, 0, 0, 64'h77); step(); idle_in();
    step(10);
    check("t5_no_timeout_yet", timeout, 0);
    step(10);
    check("t5_timeout", timeout, 1);
    do_clear();
    check("t5_timeout_cleared", timeout, 0);
    check("t5_queue_kept", idle, 0);

    // async reset mid-run discards queued beats
    put(REF, 0, 2, 64'h88); put(DUT, 1, 1, 64'h99);
    put(REF, 1, 0, 64'h5);  put(DUT, 1, 0, 64'h5);
    step(); idle_in(); step(3);
    check("t6_pre_match_cnt", match_cnt, 1);
    check("t6_pre_busy", idle, 0);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_match_cnt", match_cnt, 0);
    check("t6_rst_idle", idle, 1);
    step();
    rst = 1'b0;
    step();
    put(REF, 0, 0, 64'h55); put(DUT, 0, 0, 64'h55);
    step(); idle_in(); step(3);
    check("t6_post_match_cnt", match_cnt, 1);
    check("t6_post_mismatch", mismatch, 0);
    check("t6_post_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
